// File: rtl/shadow_commit_pkg.sv
// Shared types and helpers for the shadow/commit register bank.
// Channel slicing and counter sizing live here so every file agrees.
package shadow_commit_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;

   localparam int MIN_CNT_W = 1;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic int slice_lo(input int c, input int w);
      return c * w;
   endfunction

endpackage

// File: rtl/shadow_commit_chan.sv
// One channel: shadow copy, committed output copy and dirty flag.
// Writes in the commit cycle are folded straight into the output.
module shadow_commit_chan
   import shadow_commit_pkg::*;
#(
   parameter int               WIDTH = 1,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             commit_go,
   output logic [WIDTH-1:0] q,
   output logic             dirty
);

   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] nxt;

   assign nxt = wr_en ? wr_data : shadow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= INIT;
         q      <= INIT;
         dirty  <= 1'b0;
      end else begin
         shadow <= nxt;
         if (commit_go) begin
            q <= nxt;
         end
         dirty <= commit_go ? 1'b0 : (dirty | wr_en);
      end
   end

endmodule

// File: rtl/shadow_commit_reg.sv
// Multi-channel shadow/commit bank: all channels reach Q_OUT together
// on COMMIT or, optionally, after a quiet period with no writes.
module shadow_commit_reg
   import shadow_commit_pkg::*;
#(
   parameter int               WIDTH        = 1,
   parameter int               CHANNELS     = 4,
   parameter logic [WIDTH-1:0] INIT         = '0,
   parameter bit               AUTO_COMMIT  = 1'b0,
   parameter int               QUIET_CYCLES = 4
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic [CHANNELS-1:0]       WR_EN,
   input  logic [WIDTH*CHANNELS-1:0] WR_DATA,
   input  logic                      COMMIT,
   output logic [WIDTH*CHANNELS-1:0] Q_OUT,
   output logic [CHANNELS-1:0]       DIRTY,
   output logic                      PENDING,
   output logic                      UPDATED
);

   localparam int CW_RAW = clog2(QUIET_CYCLES + 1);
   localparam int CW = (CW_RAW > MIN_CNT_W) ? CW_RAW : MIN_CNT_W;
   localparam logic [CW-1:0] QMAX  = CW'(QUIET_CYCLES);
   localparam logic [CW-1:0] QLAST = CW'(QUIET_CYCLES - 1);

   state_t        state;
   logic [CW-1:0] quiet_cnt;
   logic          any_wr;
   logic          auto_fire;
   logic          commit_go;

   assign any_wr    = |WR_EN;
   assign auto_fire = AUTO_COMMIT
                    && (state == PEND)
                    && !any_wr
                    && (quiet_cnt == QLAST);
   assign commit_go = COMMIT | auto_fire;
   assign PENDING   = (state == PEND);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= IDLE;
         quiet_cnt <= '0;
         UPDATED   <= 1'b0;
      end else begin
         UPDATED <= commit_go;
         unique case (state)
            IDLE: begin
               if (any_wr && !commit_go) begin
                  state     <= PEND;
                  quiet_cnt <= '0;
               end
            end
            PEND: begin
               if (commit_go) begin
                  state     <= IDLE;
                  quiet_cnt <= '0;
               end else if (any_wr) begin
                  quiet_cnt <= '0;
               end else if (quiet_cnt != QMAX) begin
                  quiet_cnt <= quiet_cnt + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               quiet_cnt <= '0;
            end
         endcase
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      shadow_commit_chan #(
         .WIDTH (WIDTH),
         .INIT  (INIT)
      ) u_chan (
         .clk       (CLK),
         .rst_n     (RST_N),
         .wr_en     (WR_EN[c]),
         .wr_data   (WR_DATA[slice_lo(c, WIDTH) +: WIDTH]),
         .commit_go (commit_go),
         .q         (Q_OUT[slice_lo(c, WIDTH) +: WIDTH]),
         .dirty     (DIRTY[c])
      );
   end

endmodule
